// File: rtl/matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// matmul_seq_ctrl
//   Top-level sequencer for the 4-lane multiply-accumulate ALU. It loads one
//   ROWS-word input matrix into the shift buffer through a valid/ready stream,
//   enables the ALU, and serialises each group of four lane results into the
//   result RAM. It reports busy/done/err status to the host controller.
//
//   Main FSM: IDLE -> LOAD -> COMPUTE -> DRAIN -> FINISH -> IDLE.
//   The result writer is a separate engine that is armed only in COMPUTE and
//   DRAIN. Each alu_web pulse produces a four-cycle RAM burst.
//
// Optional build macro:
//   MATMUL_WDOG_EN - adds a 64-cycle COMPUTE watchdog. On timeout it sets err,
//                    drops alu_en, skips DRAIN and goes straight to FINISH.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start                  begin a job (sampled in IDLE only)
//   in_valid/in_data       input row stream; in_ready is high throughout LOAD
//   buf_we/addr/wdata      input shift-buffer write port (wdata = in_data)
//   alu_en                 ALU enable, high throughout COMPUTE
//   alu_web, alu_done      ALU group-complete and job-complete strobes
//   mu1..mu4               ALU lane results, valid while alu_web is high
//   ram_we/addr/wdata      result RAM write port, addr = {group, lane}
//   busy, done, err        host status (done is a pulse, err is sticky)
// -----------------------------------------------------------------------------
module matmul_seq_ctrl #(
    parameter int ROWS    = 8,
    parameter int DATA_W  = 64,
    parameter int RES_W   = 18,
    parameter int GROUPS  = 4,
    parameter int RADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    buf_we,
    output logic [$clog2(ROWS)-1:0] buf_addr,
    output logic [DATA_W-1:0]       buf_wdata,
    output logic                    alu_en,
    input  logic                    alu_web,
    input  logic                    alu_done,
    input  logic [RES_W-1:0]        mu1,
    input  logic [RES_W-1:0]        mu2,
    input  logic [RES_W-1:0]        mu3,
    input  logic [RES_W-1:0]        mu4,
    output logic                    ram_we,
    output logic [RADDR_W-1:0]      ram_addr,
    output logic [RES_W-1:0]        ram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int GRP_W = RADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_COMPUTE,
        S_DRAIN,
        S_FINISH
    } state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row_cnt;
    logic [GRP_W-1:0]   grp_cnt;
    logic [1:0]         lane_cnt;
    logic               wr_active;
    logic [RES_W-1:0]   hold [4];
    logic               err_q;
    logic               xfer;
    logic               web_ok;
    logic               wr_armed;
    logic               wdog_trip;

`ifdef MATMUL_WDOG_EN
    localparam logic [6:0] WDOG_LAST = 7'd63;   // 64th COMPUTE cycle
    logic [6:0] wdog_cnt;
`endif

    // A transfer can only happen in LOAD, where in_ready is high.
    assign xfer      = in_valid && (state == S_LOAD);
    assign buf_we    = xfer;
    assign buf_addr  = row_cnt;
    assign buf_wdata = in_data;

    // The writer only listens to the ALU while a job is computing or draining.
    assign wr_armed  = (state == S_COMPUTE) || (state == S_DRAIN);
    assign web_ok    = alu_web && wr_armed;

    assign ram_we    = wr_active;
    assign ram_addr  = {grp_cnt, lane_cnt};
    assign ram_wdata = hold[lane_cnt];
    assign err       = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        alu_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        wdog_trip = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (xfer && row_cnt == ROW_W'(ROWS - 1)) state_nxt = S_COMPUTE;
            end
            S_COMPUTE: begin
                alu_en = 1'b1;
                if (alu_done) begin
                    state_nxt = S_DRAIN;
                end
`ifdef MATMUL_WDOG_EN
                else if (wdog_cnt == WDOG_LAST) begin
                    wdog_trip = 1'b1;
                    state_nxt = S_FINISH;
                end
`endif
            end
            S_DRAIN: begin
                // A pulse arriving this cycle starts a new burst, so stay put.
                if (!wr_active && !web_ok) state_nxt = S_FINISH;
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, writer engine and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_cnt   <= '0;
            grp_cnt   <= '0;
            lane_cnt  <= '0;
            wr_active <= 1'b0;
            err_q     <= 1'b0;
            // NOTE: the holding registers are reset, not left as
            // uninitialised storage, so ram_wdata reads 0 out of reset.
            for (int i = 0; i < 4; i++) hold[i] <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                err_q   <= 1'b0;
                row_cnt <= '0;
                grp_cnt <= '0;
            end

            if (xfer) begin
                row_cnt <= (row_cnt == ROW_W'(ROWS - 1)) ? '0 : row_cnt + 1'b1;
            end

            if (!wr_armed) begin
                // Only reachable mid-burst via a watchdog skip: abandon it.
                wr_active <= 1'b0;
                lane_cnt  <= '0;
            end else if (wr_active) begin
                // Overrun: flag it, drop the new results, finish this burst.
                if (alu_web) err_q <= 1'b1;
                lane_cnt <= lane_cnt + 2'd1;
                if (lane_cnt == 2'd3) begin
                    wr_active <= 1'b0;
                    grp_cnt   <= (grp_cnt == GRP_W'(GROUPS - 1)) ? '0 : grp_cnt + 1'b1;
                end
            end else if (alu_web) begin
                hold[0]   <= mu1;
                hold[1]   <= mu2;
                hold[2]   <= mu3;
                hold[3]   <= mu4;
                lane_cnt  <= '0;
                wr_active <= 1'b1;
            end

            if (wdog_trip) err_q <= 1'b1;
        end
    end

`ifdef MATMUL_WDOG_EN
    // Counts COMPUTE cycles; held at zero elsewhere so each entry starts fresh.
    always_ff @(posedge clk) begin
        if (rst || state != S_COMPUTE) wdog_cnt <= '0;
        else                           wdog_cnt <= wdog_cnt + 7'd1;
    end
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_ctrl
//   Scoreboard bench for matmul_seq_ctrl. Stimulus tasks push the expected
//   buffer and RAM writes into queues. A negedge monitor pops and compares
//   them whenever buf_we or ram_we is seen. The reference model works at the
//   transaction level: each valid word in LOAD is one buffer row, and each
//   alu_web accepted by an idle writer is one 4-word burst at {group, lane}.
//   A pulse that arrives fewer than 5 cycles after the last accepted pulse is
//   an overrun. Honours MATMUL_WDOG_EN.
// -----------------------------------------------------------------------------
module tb_matmul_seq_ctrl;

    localparam int ROWS    = 8;
    localparam int DATA_W  = 64;
    localparam int RES_W   = 18;
    localparam int GROUPS  = 4;
    localparam int RADDR_W = 4;

    logic               clk;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic               buf_we;
    logic [2:0]         buf_addr;
    logic [DATA_W-1:0]  buf_wdata;
    logic               alu_en;
    logic               alu_web;
    logic               alu_done;
    logic [RES_W-1:0]   mu1, mu2, mu3, mu4;
    logic               ram_we;
    logic [RADDR_W-1:0] ram_addr;
    logic [RES_W-1:0]   ram_wdata;
    logic               busy;
    logic               done;
    logic               err;

    matmul_seq_ctrl #(
        .ROWS(ROWS), .DATA_W(DATA_W), .RES_W(RES_W), .GROUPS(GROUPS), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .alu_en(alu_en), .alu_web(alu_web), .alu_done(alu_done),
        .mu1(mu1), .mu2(mu2), .mu3(mu3), .mu4(mu4),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        addr;
        logic [DATA_W-1:0] data;
    } buf_wr_t;

    typedef struct {
        logic [RADDR_W-1:0] addr;
        logic [RES_W-1:0]   data;
    } ram_wr_t;

    buf_wr_t buf_q[$];
    ram_wr_t ram_q[$];
    buf_wr_t mon_b;
    ram_wr_t mon_r;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (buf_we) begin
                check("buf_write_expected", 64'(buf_q.size() > 0), 64'd1);
                if (buf_q.size() > 0) begin
                    mon_b = buf_q.pop_front();
                    check("buf_addr", 64'(buf_addr), 64'(mon_b.addr));
                    check("buf_wdata", buf_wdata, mon_b.data);
                end
            end
            if (ram_we) begin
                check("ram_write_expected", 64'(ram_q.size() > 0), 64'd1);
                if (ram_q.size() > 0) begin
                    mon_r = ram_q.pop_front();
                    check("ram_addr", 64'(ram_addr), 64'(mon_r.addr));
                    check("ram_wdata", 64'(ram_wdata), 64'(mon_r.data));
                end
            end
        end
    end

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("err_cleared_by_start", 64'(err), 64'd0);
        check("in_ready_in_load", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // mode 0: continuous 0x01.. 0x08 byte patterns; 1: in_valid toggling plus
    // a start pulse in LOAD; 2: random stalls and data.
    task automatic load_job(input int mode);
        int rows  = 0;
        int guard = 0;
        bit v;
        while (rows < ROWS && guard < 200) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : ($urandom_range(0, 2) != 0);
            in_valid = v;
            in_data  = (mode == 0) ? {8{8'(rows + 1)}} : {$urandom, $urandom};
            start    = (mode == 1 && guard == 3);
            if (v) buf_q.push_back('{addr: 3'(rows), data: in_data});
            @(negedge clk);
            check("alu_en_low_in_load", 64'(alu_en), 64'd0);
            @(posedge clk); #1;
            if (v) rows++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = '0;
        @(negedge clk);
        check("alu_en_after_load", 64'(alu_en), 64'd1);
        check("in_ready_after_load", 64'(in_ready), 64'd0);
        check("buf_q_drained", 64'(buf_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic randomise_mu();
        mu1 = 18'($urandom); mu2 = 18'($urandom);
        mu3 = 18'($urandom); mu4 = 18'($urandom);
    endtask

    // Issues n alu_web pulses, then alu_done. The model decides which pulses
    // become bursts (writer free for 4 cycles after each accepted pulse).
    task automatic run_compute(input int n, input bit directed, input bit overrun_dir,
                               input bit done_with_last, output bit exp_err);
        int cyc      = 0;
        int last_acc = -100;
        int grp      = 0;
        int k;
        logic [RES_W-1:0] m [4];
        exp_err = 1'b0;
        for (int p = 0; p < n; p++) begin
            if (p > 0) begin
                k = directed ? (overrun_dir ? 2 : 8) : $urandom_range(2, 9);
                repeat (k - 1) begin tick(); cyc++; end
            end
            for (int l = 0; l < 4; l++) m[l] = directed ? 18'(l + 1 + 16 * p) : 18'($urandom);
            mu1 = m[0]; mu2 = m[1]; mu3 = m[2]; mu4 = m[3];
            alu_web  = 1'b1;
            alu_done = done_with_last && (p == n - 1);
            if (cyc - last_acc >= 5) begin
                for (int l = 0; l < 4; l++)
                    ram_q.push_back('{addr: 4'((grp % GROUPS) * 4 + l), data: m[l]});
                grp++;
                last_acc = cyc;
            end else begin
                exp_err = 1'b1;
            end
            tick(); cyc++;
            alu_web  = 1'b0;
            alu_done = 1'b0;
            randomise_mu();
        end
        if (!done_with_last) begin
            repeat ($urandom_range(0, 3)) tick();
            alu_done = 1'b1;
            tick();
            alu_done = 1'b0;
        end
        @(negedge clk);
        check("alu_en_low_after_done", 64'(alu_en), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input bit exp_err);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("writes_complete_before_done", 64'(ram_q.size()), 64'd0);
            check("busy_with_done", 64'(busy), 64'd1);
            check("err_at_done", 64'(err), 64'(exp_err));
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
            check("err_sticky_in_idle", 64'(err), 64'(exp_err));
        end
        ram_q.delete();
        @(posedge clk); #1;
    endtask

    bit e;
    int en_cycles;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        alu_web = 1'b0; alu_done = 1'b0;
        mu1 = '0; mu2 = '0; mu3 = '0; mu4 = '0;
        tick(); tick();
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_alu_en", 64'(alu_en), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_addr", 64'(ram_addr), 64'd0);
        check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
        check("rst_buf_we", 64'(buf_we), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // alu_web while IDLE must not start a burst (monitor flags any write).
        randomise_mu();
        alu_web = 1'b1;
        tick();
        alu_web = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("idle_web_ram_we", 64'(ram_we), 64'd0);
        check("idle_web_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Basic job with directed results: 16 writes, addresses 0..15.
        start_job();
        load_job(0);
        run_compute(4, 1'b1, 1'b0, 1'b0, e);
        wait_done(e);

        // Stalled load with a start pulse in LOAD, random compute phase.
        start_job();
        load_job(1);
        run_compute(3, 1'b0, 1'b0, 1'b1, e);
        wait_done(e);

        // Directed overrun: second pulse 2 cycles after the first.
        start_job();
        load_job(0);
        run_compute(2, 1'b1, 1'b1, 1'b0, e);
        check("overrun_model_flag", 64'(e), 64'd1);
        wait_done(e);

        // Randomised jobs (group wrap, overruns, done with last pulse).
        for (int j = 0; j < 6; j++) begin
            start_job();
            load_job(2);
            run_compute($urandom_range(1, 6), 1'b0, 1'b0, 1'($urandom_range(0, 1)), e);
            wait_done(e);
        end

        // Reset in the middle of COMPUTE with a burst in flight.
        start_job();
        load_job(2);
        randomise_mu();
        alu_web = 1'b1;
        ram_q.push_back('{addr: 4'd0, data: mu1});
        ram_q.push_back('{addr: 4'd1, data: mu2});
        tick();
        alu_web = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_alu_en", 64'(alu_en), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_ram_we", 64'(ram_we), 64'd0);
        check("midrst_err", 64'(err), 64'd0);
        ram_q.delete();
        @(posedge clk); #1;

`ifdef MATMUL_WDOG_EN
        // No alu_done: the watchdog ends COMPUTE after 64 cycles.
        start_job();
        load_job(0);
        en_cycles = 1;
        for (int i = 0; i < 200 && alu_en; i++) begin
            @(negedge clk);
            if (alu_en) en_cycles++;
            else begin
                check("wdog_done_pulse", 64'(done), 64'd1);
                check("wdog_err", 64'(err), 64'd1);
            end
            @(posedge clk); #1;
        end
        check("wdog_compute_cycles", 64'(en_cycles), 64'd64);
        @(negedge clk);
        check("wdog_busy_after", 64'(busy), 64'd0);
        @(posedge clk); #1;
`else
        // No watchdog: COMPUTE waits for alu_done indefinitely.
        start_job();
        load_job(0);
        en_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (alu_en) en_cycles++;
            @(posedge clk); #1;
        end
        check("nowdog_alu_en_held", 64'(en_cycles), 64'd100);
        check("nowdog_err", 64'(err), 64'd0);
        run_compute(1, 1'b0, 1'b0, 1'b1, e);
        wait_done(e);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Top-level sequencer for the 4-lane multiply-accumulate ALU.
- Loads an 8-row input matrix into the shift buffer through a valid/ready stream, then runs the ALU.
- Serialises the four 18-bit lane results of each output group into the result RAM.
- Reports completion and error status to the host controller.

Parameters:
- ROWS, 8: input words per matrix.
- DATA_W, 64: input word width (8 x 8-bit elements).
- RES_W, 18: ALU lane result width.
- GROUPS, 4: output groups per matrix (one alu_web pulse each).
- RADDR_W, 4: result RAM address width, equal to log2(GROUPS*4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin one matrix job; sampled in IDLE only.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input matrix row.
- in_ready  out  1  controller accepts a word.
- buf_we  out  1  input buffer write strobe.
- buf_addr  out  3  input buffer row index.
- buf_wdata  out  DATA_W  equals in_data, combinational pass-through.
- alu_en  out  1  ALU enable.
- alu_web  in  1  ALU group-complete strobe.
- alu_done  in  1  ALU job-complete strobe.
- mu1, mu2, mu3, mu4  in  RES_W each  ALU lane results; valid in the cycle alu_web is high.
- ram_we  out  1  result RAM write enable.
- ram_addr  out  RADDR_W  result RAM address.
- ram_wdata  out  RES_W  result RAM write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky error flag, cleared by start or rst.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE; all outputs 0; row, group and lane counters 0; holding registers 0.
- States: IDLE -> LOAD -> COMPUTE -> DRAIN -> FINISH -> IDLE.
- IDLE:
  - start=1 clears err, row counter and group counter, then moves to LOAD.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - A transfer is in_valid & in_ready. Each transfer asserts buf_we combinationally, with buf_addr = row count.
  - The row counter increments per transfer.
  - The cycle of the ROWS-th transfer moves to COMPUTE. in_ready=0 from the next cycle.
  - in_valid=0 stalls indefinitely with no timeout.
- COMPUTE:
  - alu_en=1 from the first COMPUTE cycle.
  - alu_done sampled high moves to DRAIN. alu_en=0 from the next cycle.
- DRAIN: waits for the writer to go idle, then moves to FINISH.
- FINISH: done=1 for exactly one cycle, then IDLE. busy falls in the same cycle done falls.
- Writer (runs independently of the main FSM in COMPUTE and DRAIN):
  - alu_web=1 latches mu1..mu4 into holding registers.
  - For the next 4 cycles: ram_we=1, ram_addr={group[1:0], lane[1:0]}, ram_wdata=held mu(lane+1) for lane 0..3.
  - The group counter increments after lane 3. It wraps at GROUPS and does not saturate.
  - ram_we=0 whenever the writer is idle.
- Overrun: alu_web while the writer is mid-burst (lanes 0..3 active) sets err=1. The new values are dropped and the current burst completes unaltered.
- Simultaneous events:
  - alu_web and alu_done in the same cycle: the burst is captured, then DRAIN waits for it to finish.
  - alu_web in any state other than COMPUTE or DRAIN is ignored.
- rst mid-job: immediate return to IDLE with all outputs at reset values. Any partial RAM burst is abandoned.
- Arithmetic: counters are unsigned and sized to their ranges. No arithmetic is performed on data.

Optional Feature:
- Macro: MATMUL_WDOG_EN.
- Enabled:
  - A 7-bit watchdog counts cycles spent in COMPUTE.
  - If 64 cycles elapse without alu_done: set err=1, force alu_en=0, skip DRAIN, go to FINISH (done pulses).
  - The watchdog clears on COMPUTE entry.
- Disabled: no watchdog logic. COMPUTE waits for alu_done indefinitely; err is set by overrun only.

Test Plan:
- Basic job: rst, start, 8 words 0x0101..0808 with continuous in_valid -> buf_we high 8 cycles with buf_addr 0..7; alu_en rises the next cycle; done pulses once; busy=0 afterwards.
- Result writes: 4 alu_web pulses 8 cycles apart, mu1..4=1,2,3,4 plus 16*group -> 16 RAM writes, addresses 0..15 in order, data matching; alu_done after the last pulse -> done after the final write.
- Stalled load: in_valid toggling 1/0 -> exactly 8 buf_we strobes with correct addr; COMPUTE entered only after the 8th.
- Overrun: second alu_web 2 cycles after the first -> err=1; only 4 writes occur, carrying the first values.
- Reset mid-COMPUTE, and start while busy: rst during COMPUTE -> next cycle alu_en=0, busy=0, ram_we=0; start asserted in LOAD -> no effect.
- Watchdog (MATMUL_WDOG_EN): no alu_done -> alu_en falls after 64 COMPUTE cycles, err=1, done pulses.
